// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order register write-back FIFO with one-hot bank strobe
// Exports a pending bitmap of queued destinations for RAW hazard detection.
module reg_writeback_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int DEPTH      = 4,
   localparam int AW = $clog2(NUM_REGS),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  drain_en,
   input  logic                  flush,
   output logic [NUM_REGS-1:0]   enable,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [NUM_REGS-1:0]   pending,
   output logic [CW-1:0]         count
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0]         addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic                  push;
   logic                  pop;

   // Addresses at or beyond NUM_REGS decode to no strobe and no pending bit.
   function automatic logic [NUM_REGS-1:0] decode(input logic [AW-1:0] a);
      logic [NUM_REGS-1:0] d;
      d = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (a == AW'(r)) d[r] = 1'b1;
      end
      return d;
   endfunction

   assign wr_ready = (count < CW'(DEPTH)) && !flush;
   assign push     = wr_valid && wr_ready;
   assign pop      = drain_en && (count != '0) && !flush;

   always_comb begin
      logic [PW-1:0] offset;
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PW'(i) - head;
         if (CW'(offset) < count) pending = pending | decode(addr_mem[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         addr_mem[tail] <= wr_addr;
         data_mem[tail] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         enable    <= '0;
         load_data <= '0;
      end else if (flush) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         enable <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) begin
            head      <= head + 1'b1;
            enable    <= decode(addr_mem[head]);
            load_data <= data_mem[head];
         end else begin
            enable <= '0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule
